alu_exec_wb: RTL

- Execute/writeback stage sitting directly in front of the 64x32 register file.
- Accepts register-addressed ALU instructions over a valid/ready handshake and drives the register file read addresses (RA1/RA2).
- Computes a 32-bit result from RD1/RD2 and drives the write port (WA/WD/WE1) one cycle later.
- Two-stage pipeline (E, W) with RAW-hazard handling and an iterative multi-cycle multiply.

---
 rtl/alu_exec_wb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_wb.sv
// alu_exec_wb: two-stage execute/writeback stage in front of a 64x32 register file.
// E reads the register file combinationally and computes a result.
// W drives the write port for exactly one cycle.
// MUL is a 1+MUL_STEPS cycle shift-add sequence held in E.
// Optional macro ALU_WB_BYPASS_EN selects how a RAW hazard against W is resolved:
//   defined   - W's write data is forwarded into E, so there is no stall;
//   undefined - E holds one extra cycle and W carries a bubble.

module alu_exec_wb #(
  parameter int CNT_W     = 16,
  parameter int MUL_STEPS = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [5:0]       in_ra1,
  input  logic [5:0]       in_ra2,
  input  logic [5:0]       in_wa,
  output logic [5:0]       RA1,
  output logic [5:0]       RA2,
  input  logic [31:0]      RD1,
  input  logic [31:0]      RD2,
  output logic [5:0]       WA,
  output logic [31:0]      WD,
  output logic             WE1,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count
);

  localparam int              MC_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [MC_W-1:0] MUL_LAST = MC_W'(MUL_STEPS - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  // Result of the single-cycle opcodes; anything else yields zero.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU: r = {31'd0, (a < b)};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic                   e_valid_r;
  logic [3:0]             e_op_r;
  logic [5:0]             e_ra1_r;
  logic [5:0]             e_ra2_r;
  logic [5:0]             e_wa_r;
  logic                   w_valid_r;
  logic                   mul_busy_r;
  logic [MC_W-1:0]        mul_cnt_r;
  logic [31:0]            mul_a_r;
  logic [31:0]            mul_b_r;
  logic [31:0]            mul_acc_r;
  logic [CNT_W-1:0]       wr_count_r;

  logic                   hz1_s;
  logic                   hz2_s;
  logic                   need_ops_s;
  logic                   stall_s;
  logic [31:0]            opa_s;
  logic [31:0]            opb_s;
  logic [31:0]            mul_sum_s;
  logic                   e_done_s;
  logic [31:0]            result_s;

  assign RA1      = e_ra1_r;
  assign RA2      = e_ra2_r;
  assign in_ready = !e_valid_r || e_done_s;
  assign busy     = e_valid_r || w_valid_r;
  assign wr_count = wr_count_r;

  // Hazard detection, operand selection and E completion.
  always_comb begin
    need_ops_s = e_valid_r && ((e_op_r <= OP_SLTU) || ((e_op_r == OP_MUL) && !mul_busy_r));
    hz1_s      = need_ops_s && WE1 && (WA == e_ra1_r);
    hz2_s      = need_ops_s && WE1 && (WA == e_ra2_r);
`ifdef ALU_WB_BYPASS_EN
    stall_s    = 1'b0;
    opa_s      = hz1_s ? WD : RD1;
    opb_s      = hz2_s ? WD : RD2;
`else
    stall_s    = hz1_s || hz2_s;
    opa_s      = RD1;
    opb_s      = RD2;
`endif
    mul_sum_s  = mul_acc_r + (mul_b_r[0] ? mul_a_r : 32'd0);
    if (!e_valid_r || stall_s) begin
      e_done_s = 1'b0;
    end else if (e_op_r == OP_MUL) begin
      e_done_s = mul_busy_r && (mul_cnt_r == MUL_LAST);
    end else begin
      e_done_s = 1'b1;
    end
    result_s   = (e_op_r == OP_MUL) ? mul_sum_s : alu_f(e_op_r, opa_s, opb_s);
  end

  // E register capture on handshake; retire when E completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_valid_r <= 1'b0;
      e_op_r    <= 4'd0;
      e_ra1_r   <= 6'd0;
      e_ra2_r   <= 6'd0;
      e_wa_r    <= 6'd0;
    end else if (in_valid && in_ready) begin
      e_valid_r <= 1'b1;
      e_op_r    <= in_op;
      e_ra1_r   <= in_ra1;
      e_ra2_r   <= in_ra2;
      e_wa_r    <= in_wa;
    end else if (e_done_s) begin
      e_valid_r <= 1'b0;
    end
  end

  // Iterative multiply: latch operands, then one shift-add step per cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mul_busy_r <= 1'b0;
      mul_cnt_r  <= '0;
      mul_a_r    <= 32'd0;
      mul_b_r    <= 32'd0;
      mul_acc_r  <= 32'd0;
    end else if (e_valid_r && (e_op_r == OP_MUL) && !stall_s) begin
      if (!mul_busy_r) begin
        mul_busy_r <= 1'b1;
        mul_cnt_r  <= '0;
        mul_a_r    <= opa_s;
        mul_b_r    <= opb_s;
        mul_acc_r  <= 32'd0;
      end else if (e_done_s) begin
        mul_busy_r <= 1'b0;
      end else begin
        mul_acc_r  <= mul_sum_s;
        mul_a_r    <= mul_a_r << 1;
        mul_b_r    <= mul_b_r >> 1;
        mul_cnt_r  <= mul_cnt_r + MC_W'(1);
      end
    end
  end

  // W stage: one-cycle write pulse; a stall or NOP leaves WE1 low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_valid_r <= 1'b0;
      WE1       <= 1'b0;
      WA        <= 6'd0;
      WD        <= 32'd0;
    end else if (e_done_s) begin
      w_valid_r <= 1'b1;
      WE1       <= (e_op_r <= OP_MUL);
      if (e_op_r <= OP_MUL) begin
        WA <= e_wa_r;
        WD <= result_s;
      end
    end else begin
      w_valid_r <= 1'b0;
      WE1       <= 1'b0;
    end
  end

  // Count committed writes, wrapping naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_count_r <= '0;
    end else if (WE1) begin
      wr_count_r <= wr_count_r + CNT_W'(1);
    end
  end

endmodule
